// File: rtl/shift_frame_sequencer_pkg.sv
// Shared constants for the shift frame sequencer and the shift register it drives.
//   - SR_* : shift register mode codes (sr_mode pins).
//   - ST_* : sequencer state encoding.
//   - shift_mode() : strobe mode for a frame direction.
package shift_ctrl_pkg;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_LEFT  = 2'b01;
  localparam logic [1:0] SR_RIGHT = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // dir = 0 shifts left (MSB out first), dir = 1 shifts right.
  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? SR_RIGHT : SR_LEFT;
  endfunction

endpackage

// File: rtl/shift_frame_sequencer_if.sv
// Upstream word handshake for the shift frame sequencer.
//   in_valid / in_ready : valid/ready handshake (transfer when both high at a clock edge).
//   in_data             : word to serialise.
//   in_dir              : 0 = left shift (MSB first), 1 = right shift.
//   in_fill             : serial_in value for the whole frame.
// master = word producer, slave = sequencer.
interface shift_frame_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             in_fill;
  logic             in_ready;

  modport master (
    output in_valid, in_data, in_dir, in_fill,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_fill,
    output in_ready
  );
endinterface

// File: rtl/shift_frame_sequencer_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
//   clk, reset_n : clock, asynchronous active-low reset.
//   clear        : synchronous return to 0 (priority over enable).
//   enable       : advance the count.
//   tick         : high on the terminal count while enabled.
module bit_period_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/shift_frame_sequencer.sv
// Shift frame sequencer: accepts words over a valid/ready handshake and drives a
// universal shift register through one LOAD plus WIDTH evenly spaced shift strobes.
//   clk, reset_n  : clock, asynchronous active-low reset.
//   up            : upstream word handshake (slave side).
//   flush         : synchronous abort of the current frame.
//   sr_mode       : shift register mode (hold/left/right/load).
//   sr_data       : shift register parallel data.
//   sr_serial_in  : shift register serial input (frame fill bit).
//   busy          : high outside IDLE.
//   shift_cnt     : strobes issued in the current frame.
//   frame_done    : one-cycle pulse at frame completion.
module shift_frame_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  shift_frame_sequencer_if.slave       up,
  input  logic                         flush,
  output logic [1:0]                   sr_mode,
  output logic [WIDTH-1:0]             sr_data,
  output logic                         sr_serial_in,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         frame_done
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic [2:0]       state, state_nx;
  logic [1:0]       mode_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             done_nx;
  logic [GW-1:0]    gap_cnt, gap_nx;
  logic             dir_q;
  logic             accept;
  logic             tick;

  assign up.in_ready = (state == ST_IDLE);
  assign accept      = (state == ST_IDLE) && up.in_valid;

  // All outputs are registered, so a strobe visible in cycle t is decided in
  // cycle t-1. The timer therefore starts counting in the LOAD cycle, which
  // puts strobe k exactly CLKS_PER_BIT*k cycles after LOAD.
  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable ((state == ST_LOAD) || (state == ST_SHIFT)),
    .tick   (tick)
  );

  always_comb begin
    state_nx = state;
    mode_nx  = SR_HOLD;
    cnt_nx   = shift_cnt;
    done_nx  = 1'b0;
    gap_nx   = gap_cnt;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_LOAD;
          mode_nx  = SR_LOAD;
          cnt_nx   = '0;
        end
      end
      ST_LOAD, ST_SHIFT: begin
        state_nx = ST_SHIFT;
        // shift_cnt reaching WIDTH means the last strobe is on the pins now.
        if (shift_cnt == CNT_FULL) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end else if (tick) begin
          mode_nx = shift_mode(dir_q);
          cnt_nx  = shift_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (GAP_CYCLES == 0) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          state_nx = ST_GAP;
          gap_nx   = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase

    // An accept in IDLE takes precedence over a coincident flush.
    if (flush && (state != ST_IDLE)) begin
      state_nx = ST_IDLE;
      mode_nx  = SR_HOLD;
      cnt_nx   = '0;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      sr_mode      <= SR_HOLD;
      sr_data      <= '0;
      sr_serial_in <= 1'b0;
      shift_cnt    <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      gap_cnt      <= '0;
      dir_q        <= 1'b0;
    end else begin
      state      <= state_nx;
      sr_mode    <= mode_nx;
      shift_cnt  <= cnt_nx;
      frame_done <= done_nx;
      busy       <= (state_nx != ST_IDLE);
      gap_cnt    <= gap_nx;
      if (accept) begin
        sr_data      <= up.in_data;
        sr_serial_in <= up.in_fill;
        dir_q        <= up.in_dir;
      end
    end
  end
endmodule

// File: doc/shift_frame_sequencer.md
Name: shift_frame_sequencer

Overview:
Upstream control stage for the 8-bit universal shift register. It accepts parallel words over a valid/ready handshake and drives the register's mode, parallel-data and serial-in pins to serialise each word.
- Each frame is one LOAD followed by WIDTH evenly spaced shift strobes, in a per-frame direction, with a per-frame fill bit.
- Reports progress and a frame-complete pulse to the downstream consumer.

Parameters:
- WIDTH, 8: word width; equals shift register width.
- CLKS_PER_BIT, 4: cycles per bit period. Must be ≥1. A shift strobe occurs on the last cycle of each period.
- GAP_CYCLES, 1: idle cycles enforced after frame_done before the next accept. 0 is legal.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  WIDTH  word to serialise.
- in_dir  in  1  0 = left shift (MSB out first), 1 = right shift.
- in_fill  in  1  bit fed into the register's serial_in for the whole frame.
- in_ready  out  1  high only in IDLE.
- flush  in  1  synchronous abort of the current frame.
- sr_mode  out  2  to shift register mode: 00 hold, 01 left, 10 right, 11 load.
- sr_data  out  WIDTH  to shift register data_in.
- sr_serial_in  out  1  to shift register serial_in.
- busy  out  1  high in any state except IDLE.
- shift_cnt  out  clog2(WIDTH+1)  number of strobes issued in the current frame.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - sr_mode=00, sr_data=0, sr_serial_in=0, shift_cnt=0, frame_done=0, busy=0.
  - in_ready is a decode of IDLE, so it reads 1 during reset, but no accept occurs until reset_n is high at a clock edge.
- All outputs except in_ready are registered.
- States: IDLE -> LOAD -> SHIFT -> DONE -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0.
- IDLE:
  - sr_mode=00.
  - An edge with in_valid & in_ready captures in_data, in_dir and in_fill into internal registers; the next state is LOAD.
- LOAD (exactly 1 cycle):
  - sr_mode=11, sr_data=captured word, sr_serial_in=captured fill.
  - Bit timer cleared; shift_cnt=0.
- SHIFT:
  - Bit timer counts 0..CLKS_PER_BIT-1. On terminal count, sr_mode = 01 if dir=0, else 10, for exactly one cycle, and shift_cnt increments in that same cycle.
  - sr_mode=00 on all other cycles.
  - sr_serial_in holds the fill bit for the whole frame. sr_data holds the captured word.
  - After the WIDTH-th strobe, the next state is DONE.
- DONE (1 cycle): frame_done=1, sr_mode=00, shift_cnt=WIDTH.
- GAP (GAP_CYCLES cycles): sr_mode=00. shift_cnt is cleared on entry to IDLE.
- Latency for an accept at edge of cycle 0:
  - LOAD in cycle 1.
  - Strobe k in cycle 1+k·CLKS_PER_BIT.
  - frame_done in cycle 2+WIDTH·CLKS_PER_BIT.
  - in_ready high again in cycle 3+WIDTH·CLKS_PER_BIT+GAP_CYCLES.
- Upstream holding: in_valid/in_data changes while busy are ignored. A word held valid is accepted in the first IDLE cycle.
- Flush:
  - A flush sampled high in any non-IDLE state forces IDLE at the next edge: sr_mode=00, shift_cnt=0, no frame_done.
  - flush in IDLE has no effect.
  - flush coincident with an accept edge in IDLE: the accept wins.
  - flush in the DONE cycle: the frame_done pulse still appears in that cycle; GAP is skipped.
- Reset mid-frame: immediate return to reset values; no frame_done.
- CLKS_PER_BIT=1: strobes on consecutive cycles; sr_mode never returns to 00 between bits.

Decomposition:
- Package shift_ctrl_pkg:
  - Mode codes SR_HOLD=2'b00, SR_LEFT=2'b01, SR_RIGHT=2'b10, SR_LOAD=2'b11.
  - State encoding for IDLE/LOAD/SHIFT/DONE/GAP.
  - The same mode codes are shared with the shift register.
- One sub-module, bit_period_timer: parameter CLKS_PER_BIT; inputs clk, reset_n, clear, enable; output tick on the terminal count.

Test Plan:
1. Basic left frame (defaults): accept in_data=8'hA5, dir=0, fill=0 at cycle 0 -> sr_mode=11 with sr_data=A5 in cycle 1; sr_mode=01 in cycles 5,9,…,33; frame_done in 34; in_ready in 36. A connected shift register ends at 8'h00, and its MSB sequence is 1,0,1,0,0,1,0,1.
2. Right frame with fill: in_data=8'h3C, dir=1, fill=1 -> sr_mode=10 at the same cycles; shift_cnt steps 1..8; register ends at 8'hFF.
3. Back-to-back: in_valid held high with two words -> second accept in cycle 36. GAP_CYCLES=0 build: second accept in cycle 35.
4. Flush after 3 strobes -> IDLE next cycle, shift_cnt=0, no frame_done; a new word is accepted cleanly afterwards.
5. reset_n pulsed low mid-SHIFT (asynchronous, between edges) -> all outputs at reset values immediately; no strobe or frame_done leaks.
6. CLKS_PER_BIT=1 build, word 8'h81 -> 8 consecutive strobe cycles 2..9; frame_done in cycle 10.
